// File: rtl/mult_error_stats.sv
// mult_error_stats: streams (x, y, approximate prod) samples, recomputes the
// exact product and accumulates error-distance statistics over a fixed run of
// N_SAMPLES accepted samples (count, erroneous count, saturating ED sum, max ED
// with the operands of the first sample that reached it).
module mult_error_stats #(
  parameter int unsigned W         = 8,
  parameter int unsigned N_SAMPLES = 65536,
  parameter int unsigned ACC_W     = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic [2*W:0]     prod,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sample_cnt,
  output logic [31:0]      err_cnt,
  output logic [ACC_W-1:0] ed_sum,
  output logic [2*W:0]     ed_max,
  output logic [W-1:0]     worst_x,
  output logic [W-1:0]     worst_y
);

  localparam int unsigned PW = 2*W + 1;
  localparam int unsigned EW = 2*W;
  localparam int unsigned SW = ACC_W + 1;
  localparam logic [31:0] LAST_IDX = 32'(N_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state;
  logic [31:0]     acc_cnt;

  logic            v1;
  logic [W-1:0]    x1;
  logic [W-1:0]    y1;
  logic [PW-1:0]   p1;
  logic [PW-1:0]   e1;

  logic            v2;
  logic [W-1:0]    x2;
  logic [W-1:0]    y2;
  logic [PW-1:0]   ed2;

  logic            accept_c;
  logic            start_ok_c;
  logic [EW-1:0]   exact_c;
  logic [SW-1:0]   sum_c;

  assign accept_c   = in_valid & in_ready;
  assign start_ok_c = start & ((state == IDLE) | (state == DONE));
  assign exact_c    = EW'(x) * EW'(y);
  assign sum_c      = SW'(ed_sum) + SW'(ed2);

  // Run control: start, count accepted samples, drain the pipeline, hold results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc_cnt  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            acc_cnt  <= '0;
          end
        end
        RUN: begin
          if (accept_c) begin
            acc_cnt <= acc_cnt + 32'd1;
            if (acc_cnt == LAST_IDX) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!v1 && !v2) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture the accepted sample and its exact product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      x1 <= '0;
      y1 <= '0;
      p1 <= '0;
      e1 <= '0;
    end else begin
      v1 <= accept_c;
      if (accept_c) begin
        x1 <= x;
        y1 <= y;
        p1 <= prod;
        e1 <= {1'b0, exact_c};
      end
    end
  end

  // Stage 2: unsigned error distance |prod - exact|
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2  <= 1'b0;
      x2  <= '0;
      y2  <= '0;
      ed2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        x2  <= x1;
        y2  <= y1;
        ed2 <= (p1 >= e1) ? (p1 - e1) : (e1 - p1);
      end
    end
  end

  // Statistics: cleared by an accepted start, updated once per drained sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
      worst_x    <= '0;
      worst_y    <= '0;
    end else if (start_ok_c) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
      worst_x    <= '0;
      worst_y    <= '0;
    end else if (v2) begin
      sample_cnt <= sample_cnt + 32'd1;
      err_cnt    <= err_cnt + 32'(ed2 != '0);
      ed_sum     <= sum_c[ACC_W] ? '1 : sum_c[ACC_W-1:0];
      // Strict compare so ties keep the earliest worst-case operands
      if (ed2 > ed_max) begin
        ed_max  <= ed2;
        worst_x <= x2;
        worst_y <= y2;
      end
    end
  end

endmodule

// File: tb/tb_mult_error_stats.sv
// Bench for mult_error_stats: five instances with different run lengths and
// accumulator widths, a queue-based reference model, a per-cycle compare
// process and directed scenarios with hand-computed expectations.
module tb_mult_error_stats;

  localparam int unsigned NI = 5;
  localparam int unsigned NS [NI] = '{4, 3, 2, 8, 65536};
  localparam int unsigned AW [NI] = '{48, 48, 48, 18, 48};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0] st = '0;
  logic [NI-1:0] vl = '0;
  logic [7:0]    x = '0;
  logic [7:0]    y = '0;
  logic [16:0]   prod = '0;

  logic        o_rdy  [NI];
  logic        o_busy [NI];
  logic        o_done [NI];
  logic [31:0] o_sc   [NI];
  logic [31:0] o_ec   [NI];
  logic [47:0] o_es   [NI];
  logic [16:0] o_em   [NI];
  logic [7:0]  o_wx   [NI];
  logic [7:0]  o_wy   [NI];
  logic [17:0] es_sat;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    if (g == 3) begin : g_sat
      mult_error_stats #(.W(8), .N_SAMPLES(NS[g]), .ACC_W(18)) u_dut (
        .clk(clk), .rst(rst), .start(st[g]), .in_valid(vl[g]), .in_ready(o_rdy[g]),
        .x(x), .y(y), .prod(prod), .busy(o_busy[g]), .done(o_done[g]),
        .sample_cnt(o_sc[g]), .err_cnt(o_ec[g]), .ed_sum(es_sat), .ed_max(o_em[g]),
        .worst_x(o_wx[g]), .worst_y(o_wy[g]));
      assign o_es[g] = 48'(es_sat);
    end else begin : g_std
      mult_error_stats #(.W(8), .N_SAMPLES(NS[g]), .ACC_W(48)) u_dut (
        .clk(clk), .rst(rst), .start(st[g]), .in_valid(vl[g]), .in_ready(o_rdy[g]),
        .x(x), .y(y), .prod(prod), .busy(o_busy[g]), .done(o_done[g]),
        .sample_cnt(o_sc[g]), .err_cnt(o_ec[g]), .ed_sum(o_es[g]), .ed_max(o_em[g]),
        .worst_x(o_wx[g]), .worst_y(o_wy[g]));
    end
  end

  int ncmp = 0;
  int nmis = 0;

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
  endtask

  task automatic chk(input int i, input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL u%0d %s: got %0d expected %0d at %0t", i, nm, act, exp, $time);
      if (nmis >= 50) begin
        summary();
        $finish;
      end
    end
  endtask

  // Reference model: accepted samples queue up with their acceptance edge and
  // become visible in the statistics two edges later; done follows three edges
  // after the last acceptance.
  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    int unsigned p;
    longint      e;
  } smp_t;

  smp_t            q [NI][$];
  bit              m_started [NI];
  int unsigned     m_nacc [NI];
  longint          m_last [NI];
  longint unsigned m_cnt [NI];
  longint unsigned m_err [NI];
  longint unsigned m_sum [NI];
  longint unsigned m_max [NI];
  logic [7:0]      m_wx [NI];
  logic [7:0]      m_wy [NI];
  longint          edge_n = 0;

  function automatic bit m_done(input int i, input longint k);
    return m_started[i] && (m_nacc[i] == NS[i]) && (k >= m_last[i] + 3);
  endfunction

  task automatic m_clear_stats(input int i);
    q[i].delete();
    m_nacc[i] = 0;
    m_cnt[i] = 0;
    m_err[i] = 0;
    m_sum[i] = 0;
    m_max[i] = 0;
    m_wx[i] = '0;
    m_wy[i] = '0;
  endtask

  always @(posedge clk or posedge rst) begin
    smp_t s;
    int unsigned ex;
    int unsigned ed;
    longint unsigned cap;
    bit pre_run;
    bit pre_done;
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        m_clear_stats(i);
        m_started[i] = 1'b0;
        m_last[i] = 0;
      end
    end else begin
      edge_n++;
      for (int i = 0; i < NI; i++) begin
        pre_run  = m_started[i] && (m_nacc[i] < NS[i]);
        pre_done = m_done(i, edge_n - 1);
        if (st[i] && (!m_started[i] || pre_done)) begin
          m_clear_stats(i);
          m_started[i] = 1'b1;
        end else if (pre_run && vl[i]) begin
          s.x = x;
          s.y = y;
          s.p = 32'(prod);
          s.e = edge_n;
          q[i].push_back(s);
          m_nacc[i]++;
          m_last[i] = edge_n;
        end
        cap = (64'd1 << AW[i]) - 64'd1;
        while (q[i].size() > 0 && q[i][0].e + 2 <= edge_n) begin
          s  = q[i].pop_front();
          ex = 32'(s.x) * 32'(s.y);
          ed = (s.p > ex) ? (s.p - ex) : (ex - s.p);
          m_cnt[i]++;
          if (ed != 0) m_err[i]++;
          m_sum[i] = (m_sum[i] + 64'(ed) > cap) ? cap : m_sum[i] + 64'(ed);
          if (64'(ed) > m_max[i]) begin
            m_max[i] = 64'(ed);
            m_wx[i] = s.x;
            m_wy[i] = s.y;
          end
        end
      end
    end
  end

  // Every cycle out of reset, every instance's outputs must match the model
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        chk(i, "in_ready",   64'(o_rdy[i]),  64'(m_started[i] && (m_nacc[i] < NS[i])));
        chk(i, "busy",       64'(o_busy[i]), 64'(m_started[i] && !m_done(i, edge_n)));
        chk(i, "done",       64'(o_done[i]), 64'(m_done(i, edge_n)));
        chk(i, "sample_cnt", 64'(o_sc[i]),   m_cnt[i]);
        chk(i, "err_cnt",    64'(o_ec[i]),   m_err[i]);
        chk(i, "ed_sum",     64'(o_es[i]),   m_sum[i]);
        chk(i, "ed_max",     64'(o_em[i]),   m_max[i]);
        chk(i, "worst_x",    64'(o_wx[i]),   64'(m_wx[i]));
        chk(i, "worst_y",    64'(o_wy[i]),   64'(m_wy[i]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int i);
    st[i] = 1'b1;
    cyc();
    st[i] = 1'b0;
  endtask

  task automatic drive(input int i, input logic [7:0] xx, input logic [7:0] yy, input logic [16:0] pp);
    vl[i] = 1'b1;
    x = xx;
    y = yy;
    prod = pp;
    cyc();
    vl[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int lim);
    int c;
    c = 0;
    while (!o_done[i] && c < lim) begin
      cyc();
      c++;
    end
    chk(i, "done_timeout", 64'(o_done[i]), 64'd1);
  endtask

  task automatic final_stats(input int i, input string tag, input logic [63:0] sc, input logic [63:0] ec,
                             input logic [63:0] es, input logic [63:0] em, input logic [63:0] wx,
                             input logic [63:0] wy);
    chk(i, {tag, ".sample_cnt"}, 64'(o_sc[i]), sc);
    chk(i, {tag, ".err_cnt"},    64'(o_ec[i]), ec);
    chk(i, {tag, ".ed_sum"},     64'(o_es[i]), es);
    chk(i, {tag, ".ed_max"},     64'(o_em[i]), em);
    chk(i, {tag, ".worst_x"},    64'(o_wx[i]), wx);
    chk(i, {tag, ".worst_y"},    64'(o_wy[i]), wy);
  endtask

  logic       hs_v [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] hs_x [6] = '{8'd7, 8'd99, 8'd12, 8'd99, 8'd200, 8'd15};
  logic [7:0] hs_y [6] = '{8'd9, 8'd99, 8'd12, 8'd99, 8'd3, 8'd15};
  logic [16:0] hs_p [6] = '{17'd60, 17'd5, 17'd150, 17'd5, 17'd590, 17'd225};

  initial begin
    int     nacc;
    longint aedge;
    bit     will_acc;

    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk(0, "reset.in_ready", 64'(o_rdy[0]), 64'd0);
    chk(0, "reset.busy", 64'(o_busy[0]), 64'd0);

    // Reset mid-run: two samples land in the statistics, then reset wipes them
    pulse(0);
    drive(0, 8'd3, 8'd5, 17'd20);
    drive(0, 8'd6, 8'd7, 17'd40);
    cyc();
    cyc();
    chk(0, "pre_rst.sample_cnt", 64'(o_sc[0]), 64'd2);
    chk(0, "pre_rst.ed_sum", 64'(o_es[0]), 64'd7);
    rst = 1'b1;
    #2;
    final_stats(0, "mid_rst", 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    chk(0, "mid_rst.in_ready", 64'(o_rdy[0]), 64'd0);
    chk(0, "mid_rst.busy", 64'(o_busy[0]), 64'd0);
    chk(0, "mid_rst.done", 64'(o_done[0]), 64'd0);
    cyc();
    rst = 1'b0;
    cyc();
    pulse(0);
    drive(0, 8'd3, 8'd5, 17'd15);
    drive(0, 8'd6, 8'd7, 17'd42);
    drive(0, 8'd255, 8'd2, 17'd510);
    drive(0, 8'd0, 8'd9, 17'd0);
    wait_done(0, 20);
    final_stats(0, "exact4", 64'd4, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);

    // Handshake gaps with a start pulse that must be ignored while running
    pulse(0);
    nacc = 0;
    aedge = 0;
    for (int k = 0; k < 6; k++) begin
      vl[0] = hs_v[k];
      st[0] = (k == 2);
      x = hs_x[k];
      y = hs_y[k];
      prod = hs_p[k];
      will_acc = hs_v[k] && o_rdy[0];
      cyc();
      st[0] = 1'b0;
      vl[0] = 1'b0;
      if (will_acc) begin
        nacc++;
        aedge = edge_n;
        if (nacc == 4) chk(0, "hs.ready_drop", 64'(o_rdy[0]), 64'd0);
      end
    end
    drive(0, 8'd1, 8'd1, 17'd100);
    chk(0, "hs.accepted", 64'(nacc), 64'd4);
    wait_done(0, 20);
    chk(0, "hs.done_latency", 64'(edge_n - aedge), 64'd3);
    final_stats(0, "hs", 64'd4, 64'd3, 64'd19, 64'd10, 64'd200, 64'd3);

    // Mixed errors
    pulse(1);
    drive(1, 8'd10, 8'd10, 17'd100);
    drive(1, 8'd255, 8'd255, 17'd65000);
    drive(1, 8'd3, 8'd4, 17'd20);
    wait_done(1, 20);
    final_stats(1, "mixed", 64'd3, 64'd2, 64'd33, 64'd25, 64'd255, 64'd255);

    // Tie on max keeps the earlier sample
    pulse(2);
    drive(2, 8'd2, 8'd2, 17'd9);
    drive(2, 8'd1, 8'd1, 17'd6);
    wait_done(2, 20);
    final_stats(2, "tie", 64'd2, 64'd2, 64'd10, 64'd5, 64'd2, 64'd2);

    // Saturation of an 18-bit sum
    pulse(3);
    for (int k = 0; k < 8; k++) drive(3, 8'd0, 8'd0, 17'd131071);
    wait_done(3, 20);
    final_stats(3, "sat", 64'd8, 64'd8, 64'd262143, 64'd131071, 64'd0, 64'd0);

    // Exhaustive sweep with the exact product, then a fresh run
    pulse(4);
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 256; b++)
        drive(4, 8'(a), 8'(b), 17'(a * b));
    wait_done(4, 20);
    final_stats(4, "sweep", 64'd65536, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    pulse(4);
    chk(4, "restart.sample_cnt", 64'(o_sc[4]), 64'd0);
    chk(4, "restart.busy", 64'(o_busy[4]), 64'd1);
    chk(4, "restart.done", 64'(o_done[4]), 64'd0);
    drive(4, 8'd255, 8'd255, 17'd0);
    drive(4, 8'd1, 8'd2, 17'd3);
    repeat (3) cyc();
    final_stats(4, "restart", 64'd2, 64'd2, 64'd65026, 64'd65025, 64'd255, 64'd255);

    summary();
    $finish;
  end

endmodule
